// File: rtl/step_clock_ctrl.sv
// Clock-enable generator for the SimpleRISC pipeline. It emits a one-cycle stage_en strobe
// every P clk cycles while running, or a single strobe for each step press while halted.
module step_clock_ctrl #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  input  logic                 step_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 stage_en_o,
  output logic                 slow_clk_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e               state_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic                 step_q;
  logic                 stage_en_q;
  logic                 slow_clk_q;
  logic                 halted_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic step_edge;
  logic period_end;
  logic fire;

  // A programmed period of 0 is treated as 1 so the run counter always has a valid wrap point.
  assign div_d      = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
  assign step_edge  = step_i & ~step_q;
  assign period_end = (cnt_q == (div_q - DIV_WIDTH'(1)));

  // Every edge that raises stage_en also advances slow_clk and cycle_count.
  assign fire = ((state_q == ST_HALT) && !run_i && step_edge) ||
                ((state_q == ST_RUN)  &&  run_i && period_end);

  // NOTE: all state updates use non-blocking assignments, so every branch reads pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_HALT;
      cnt_q      <= '0;
      div_q      <= DIV_WIDTH'(1);
      step_q     <= 1'b0;
      stage_en_q <= 1'b0;
      slow_clk_q <= 1'b0;
      halted_q   <= 1'b1;
      count_q    <= '0;
    end else begin
      step_q     <= step_i;
      stage_en_q <= fire;
      if (fire) begin
        slow_clk_q <= ~slow_clk_q;
        count_q    <= count_q + CNT_WIDTH'(1);
      end

      unique case (state_q)
        ST_HALT: begin
          // run has priority over a simultaneous step edge; that edge is dropped.
          if (run_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            div_q    <= div_d;
            halted_q <= 1'b0;
          end else if (step_edge) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
          end else begin
            halted_q <= 1'b1;
          end
        end

        ST_STEP: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end

        ST_RUN: begin
          if (!run_i) begin
            state_q  <= ST_HALT;
            cnt_q    <= '0;
            halted_q <= 1'b1;
          end else if (period_end) begin
            // The new period length is picked up only here, at the period boundary.
            cnt_q    <= '0;
            div_q    <= div_d;
            halted_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + DIV_WIDTH'(1);
            halted_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_HALT;
          cnt_q    <= '0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign stage_en_o    = stage_en_q;
  assign slow_clk_o    = slow_clk_q;
  assign halted_o      = halted_q;
  assign cycle_count_o = count_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Self-checking bench for step_clock_ctrl: table vectors, directed corner sequences and
// randomized stimulus against a deadline-based behavioural model.
module tb_step_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_in = 1'b0;
  logic        step_in = 1'b0;
  logic [7:0]  div_in = 8'd1;
  logic        stage_en, slow_clk, halted;
  logic [31:0] cycle_count;
  logic        s_stage_en, s_slow_clk, s_halted;
  logic [2:0]  s_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  step_clock_ctrl #(.DIV_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run_in), .step_i(step_in), .div_i(div_in),
    .stage_en_o(stage_en), .slow_clk_o(slow_clk), .halted_o(halted), .cycle_count_o(cycle_count)
  );

  // Narrow counter instance so the wrap-around of cycle_count is exercised quickly.
  step_clock_ctrl #(.DIV_WIDTH(8), .CNT_WIDTH(3)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run_in), .step_i(step_in), .div_i(div_in),
    .stage_en_o(s_stage_en), .slow_clk_o(s_slow_clk), .halted_o(s_halted),
    .cycle_count_o(s_cycle_count)
  );

  // Behavioural model: RUN strobes are scheduled as absolute edge numbers (deadlines).
  typedef enum {M_HALT, M_STEP, M_RUN} mode_e;
  mode_e       m_mode = M_HALT;
  logic        m_prev_step = 1'b0;
  int          m_k = 0;
  int          m_next_at = 0;
  logic        m_en = 1'b0;
  logic        m_slow = 1'b0;
  logic        m_halt = 1'b1;
  logic [31:0] m_cnt = 32'd0;

  function automatic int eff_period(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic fire;
    logic edge_seen;
    m_k++;
    if (!rst_n) begin
      m_mode = M_HALT; m_prev_step = 1'b0;
      m_en = 1'b0; m_slow = 1'b0; m_halt = 1'b1; m_cnt = 32'd0;
    end else begin
      edge_seen   = step_in && !m_prev_step;
      m_prev_step = step_in;
      fire        = 1'b0;
      case (m_mode)
        M_HALT: begin
          if (run_in) begin
            m_mode = M_RUN;
            m_next_at = m_k + eff_period(div_in);
          end else if (edge_seen) begin
            m_mode = M_STEP;
            fire = 1'b1;
          end
        end
        M_STEP: m_mode = M_HALT;
        M_RUN: begin
          if (!run_in) begin
            m_mode = M_HALT;
          end else if (m_k == m_next_at) begin
            fire = 1'b1;
            m_next_at = m_k + eff_period(div_in);
          end
        end
        default: m_mode = M_HALT;
      endcase
      m_en = fire;
      if (fire) begin
        m_slow = ~m_slow;
        m_cnt  = m_cnt + 32'd1;
      end
      m_halt = (m_mode == M_HALT);
    end
  endtask

  task automatic compare_model();
    check("model stage_en", {31'd0, stage_en}, {31'd0, m_en});
    check("model slow_clk", {31'd0, slow_clk}, {31'd0, m_slow});
    check("model halted", {31'd0, halted}, {31'd0, m_halt});
    check("model cycle_count", cycle_count, m_cnt);
    check("model small cycle_count wrap", {29'd0, s_cycle_count}, {29'd0, m_cnt[2:0]});
  endtask

  // One clock edge: the model advances on the same inputs, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  // Runs n edges and reports strobe statistics; tick index i is 1-based.
  task automatic run_n(input int n, output int strobes, output int first, output int last,
                       output int toggles);
    logic prev_slow;
    strobes = 0; first = 0; last = 0; toggles = 0;
    prev_slow = slow_clk;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (stage_en) begin
        strobes++;
        if (first == 0) first = i;
        last = i;
      end
      if (slow_clk != prev_slow) toggles++;
      prev_slow = slow_clk;
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        step;
    logic [7:0]  div;
    logic        exp_en;
    logic        exp_slow;
    logic        exp_halt;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int strobes, first, last, toggles;
    logic [31:0] base;

    //            rst  run  step div    en   slow halt cnt
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 32'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 32'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 32'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 32'd3};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 32'd3};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 32'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 32'd3};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 32'd3};

    // Reset with run/step active, release into HALT, short run, step, combined run+step.
    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n; run_in = vecs[i].run; step_in = vecs[i].step; div_in = vecs[i].div;
      tick();
      check($sformatf("vec%0d stage_en", i), {31'd0, stage_en}, {31'd0, vecs[i].exp_en});
      check($sformatf("vec%0d slow_clk", i), {31'd0, slow_clk}, {31'd0, vecs[i].exp_slow});
      check($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halt});
      check($sformatf("vec%0d cycle_count", i), cycle_count, vecs[i].exp_cnt);
    end

    // div=4 free run for 40 cycles after entry.
    rst_n = 1'b0; run_in = 1'b0; step_in = 1'b0; tick();
    rst_n = 1'b1; run_in = 1'b1; div_in = 8'd4; tick();
    run_n(40, strobes, first, last, toggles);
    check("div4 strobes", strobes, 10);
    check("div4 first strobe", first, 4);
    check("div4 last strobe", last, 40);
    check("div4 cycle_count", cycle_count, 32'd10);
    check("div4 slow_clk toggles", toggles, 10);

    // div=0 and div=1 both give a continuous strobe.
    run_in = 1'b0; tick();
    run_in = 1'b1; div_in = 8'd0; tick();
    run_n(6, strobes, first, last, toggles);
    check("div0 continuous", strobes, 6);
    run_in = 1'b0; tick();
    run_in = 1'b1; div_in = 8'd1; tick();
    run_n(6, strobes, first, last, toggles);
    check("div1 continuous", strobes, 6);

    // div 4 -> 2 while cnt=1: current period still ends after 4, then every 2.
    run_in = 1'b0; tick();
    run_in = 1'b1; div_in = 8'd4; tick();
    tick();
    div_in = 8'd2;
    run_n(7, strobes, first, last, toggles);
    check("div change strobes", strobes, 3);
    check("div change first", first, 3);
    check("div change last", last, 7);

    // Step held high while halted gives exactly one strobe.
    run_in = 1'b0; step_in = 1'b0; tick(); tick();
    base = cycle_count;
    step_in = 1'b1;
    run_n(10, strobes, first, last, toggles);
    check("held step strobes", strobes, 1);
    check("held step first", first, 1);
    check("held step count delta", cycle_count - base, 32'd1);
    check("held step halted", {31'd0, halted}, 32'd1);

    // Step pulses during RUN add nothing.
    step_in = 1'b0; run_in = 1'b1; div_in = 8'd3; tick();
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      step_in = ~step_in;
      tick();
      if (stage_en) strobes++;
    end
    check("run ignores step", strobes, 4);

    // Run rising together with step rising: no STEP strobe.
    run_in = 1'b0; step_in = 1'b0; tick(); tick();
    base = cycle_count;
    run_in = 1'b1; step_in = 1'b1; tick();
    check("run+step no strobe", {31'd0, stage_en}, 32'd0);
    check("run+step enters run", {31'd0, halted}, 32'd0);
    tick();
    check("run+step count", cycle_count - base, 32'd0);

    // Drop run at cnt=2 with div=4, then resume with a full period.
    run_in = 1'b0; step_in = 1'b0; tick();
    run_in = 1'b1; div_in = 8'd4; tick();
    tick(); tick();
    run_in = 1'b0; tick();
    check("drop run no strobe", {31'd0, stage_en}, 32'd0);
    check("drop run halted", {31'd0, halted}, 32'd1);
    tick();
    check("drop run still quiet", {31'd0, stage_en}, 32'd0);
    run_in = 1'b1; tick();
    run_n(4, strobes, first, last, toggles);
    check("resume first strobe", first, 4);

    // Reset in the middle of RUN.
    run_n(2, strobes, first, last, toggles);
    rst_n = 1'b0; tick();
    check("midrun rst stage_en", {31'd0, stage_en}, 32'd0);
    check("midrun rst slow_clk", {31'd0, slow_clk}, 32'd0);
    check("midrun rst halted", {31'd0, halted}, 32'd1);
    check("midrun rst cycle_count", cycle_count, 32'd0);
    rst_n = 1'b1; run_in = 1'b0; tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) run_in = ~run_in;
      if ($urandom_range(0, 2) == 0) step_in = ~step_in;
      if ($urandom_range(0, 9) == 0) div_in = 8'($urandom_range(0, 7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
